// File: rtl/bus_fifo_module.sv
// Purpose: selects one word per cycle from a packed source bus and queues it in a FIFO;
//          exposes head word, occupancy, full flag and sticky error bits.
// Latency: a push at edge N is visible on destination0 after edge N; backpressure: a push
//          into a full queue without a same-cycle pop is dropped and flagged as overflow.
//
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   selector       0 = no push; k in 1..count pushes source word k-1; larger values = no push
//   source         count packed words, word i at [(i+1)*bit_width-1 : i*bit_width]
//   pop            remove the head entry at the next edge
//   destination0   head word (0 when empty)
//   destination1   occupancy, zero-extended
//   destination2   all ones when full
//   destination3   sticky errors: bit0 overflow, bit1 underflow

`ifndef BIT_WIDTH
`define BIT_WIDTH 8
`endif

module bus_fifo_module #(
  // A source bus carrying zero words has no meaning; the smallest legal bus is one word.
  parameter int count = 1,
  parameter int depth = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [$clog2(count + 1)-1:0]      selector,
  input  logic [count*`BIT_WIDTH-1:0]       source,
  input  logic                              pop,
  output logic [`BIT_WIDTH-1:0]             destination0,
  output logic [`BIT_WIDTH-1:0]             destination1,
  output logic [`BIT_WIDTH-1:0]             destination2,
  output logic [`BIT_WIDTH-1:0]             destination3
);

  localparam int BW    = `BIT_WIDTH;
  localparam int SEL_W = $clog2(count + 1);
  localparam int PTR_W = $clog2(depth);
  localparam int OCC_W = PTR_W + 1;

  logic [BW-1:0]    mem_q [depth];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic [BW-1:0]    push_word;
  logic             push_req;
  logic             pop_req;
  logic             push_ok;
  logic             pop_ok;
  logic             empty;
  logic             full;

  assign empty = (occ_q == '0);
  assign full  = (occ_q == OCC_W'(depth));

  // Word select: only selector values 1..count match, so out-of-range codes
  // fall through as "no push" without raising any error.
  always_comb begin
    push_req  = 1'b0;
    push_word = '0;
    for (int i = 0; i < count; i++) begin
      if (selector == SEL_W'(i + 1)) begin
        push_req  = 1'b1;
        push_word = source[i*BW +: BW];
      end
    end
  end

  assign pop_req = pop;
  assign pop_ok  = pop_req && !empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push_ok = push_req && (!full || pop_ok);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push_ok, pop_ok})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    if (push_req && !push_ok) ovf_d = 1'b1;
    if (pop_req && empty)     udf_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is not reset; a write landing during reset is never visible
  // because occupancy restarts at zero.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_word;
  end

  assign destination0 = empty ? '0 : mem_q[rd_ptr_q];
  assign destination1 = BW'(occ_q);
  assign destination2 = {BW{full}};
  assign destination3 = BW'({udf_q, ovf_q});

endmodule

// File: tb/tb_bus_fifo_module.sv
`ifndef BIT_WIDTH
`define BIT_WIDTH 8
`endif

module tb_bus_fifo_module;

  localparam int COUNT = 2;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  selector = '0;
  logic [15:0] source = '0;
  logic        pop = 1'b0;
  logic [7:0]  destination0, destination1, destination2, destination3;

  int checks = 0;
  int errors = 0;

  bus_fifo_module #(.count(COUNT), .depth(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .selector     (selector),
    .source       (source),
    .pop          (pop),
    .destination0 (destination0),
    .destination1 (destination1),
    .destination2 (destination2),
    .destination3 (destination3)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        rst;
    logic [1:0]  sel;
    logic [15:0] src;
    logic        pop;
    logic [7:0]  e0, e1, e2, e3;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  task automatic add(input string name, input logic r, input logic [1:0] s, input logic [15:0] src,
                     input logic p, input logic [7:0] e0, input logic [7:0] e1,
                     input logic [7:0] e2, input logic [7:0] e3);
    vec_t v;
    v.name = name; v.rst = r; v.sel = s; v.src = src; v.pop = p;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3);
    chk({name, ".d0"}, destination0, e0);
    chk({name, ".d1"}, destination1, e1);
    chk({name, ".d2"}, destination2, e2);
    chk({name, ".d3"}, destination3, e3);
  endtask

  // Reference model for the random phase.
  logic [7:0] model_q[$];
  logic       m_ovf, m_udf;

  initial begin
    vec_t v;
    vec_t e;

    // name, rst, sel, src, pop, d0, d1, d2, d3
    add("reset",      1, 0, 16'h0000, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    add("idle0",      0, 0, 16'h5A5A, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    add("idle1",      0, 0, 16'hFFFF, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    add("sel_oor",    0, 3, 16'hABCD, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    add("push11",     0, 1, 16'h0011, 0, 8'h11, 8'h01, 8'h00, 8'h00);
    add("push22",     0, 2, 16'h2200, 0, 8'h11, 8'h02, 8'h00, 8'h00);
    add("push33",     0, 1, 16'h0033, 0, 8'h11, 8'h03, 8'h00, 8'h00);
    add("pop1",       0, 0, 16'h0000, 1, 8'h22, 8'h02, 8'h00, 8'h00);
    add("pop2",       0, 0, 16'h0000, 1, 8'h33, 8'h01, 8'h00, 8'h00);
    add("pop3",       0, 0, 16'h0000, 1, 8'h00, 8'h00, 8'h00, 8'h00);
    add("fillA1",     0, 1, 16'h00A1, 0, 8'hA1, 8'h01, 8'h00, 8'h00);
    add("fillA2",     0, 2, 16'hA200, 0, 8'hA1, 8'h02, 8'h00, 8'h00);
    add("fillA3",     0, 1, 16'h00A3, 0, 8'hA1, 8'h03, 8'h00, 8'h00);
    add("fillA4",     0, 1, 16'h00A4, 0, 8'hA1, 8'h04, 8'hFF, 8'h00);
    add("overflow",   0, 1, 16'h00A5, 0, 8'hA1, 8'h04, 8'hFF, 8'h01);
    add("full_pp55",  0, 2, 16'h5500, 1, 8'hA2, 8'h04, 8'hFF, 8'h01);
    add("drain1",     0, 0, 16'h0000, 1, 8'hA3, 8'h03, 8'h00, 8'h01);
    add("drain2",     0, 0, 16'h0000, 1, 8'hA4, 8'h02, 8'h00, 8'h01);
    add("drain3",     0, 0, 16'h0000, 1, 8'h55, 8'h01, 8'h00, 8'h01);
    add("drain4",     0, 0, 16'h0000, 1, 8'h00, 8'h00, 8'h00, 8'h01);
    add("reset2",     1, 0, 16'h0000, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    add("empty_pp77", 0, 1, 16'h0077, 1, 8'h77, 8'h01, 8'h00, 8'h02);
    add("pop77",      0, 0, 16'h0000, 1, 8'h00, 8'h00, 8'h00, 8'h02);
    add("udf_only",   0, 0, 16'h0000, 1, 8'h00, 8'h00, 8'h00, 8'h02);
    add("fill31",     0, 1, 16'h0031, 0, 8'h31, 8'h01, 8'h00, 8'h02);
    add("fill32",     0, 2, 16'h3200, 0, 8'h31, 8'h02, 8'h00, 8'h02);
    add("fill33",     0, 1, 16'h0033, 0, 8'h31, 8'h03, 8'h00, 8'h02);
    add("rst_push",   1, 1, 16'h0044, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    add("push99",     0, 2, 16'h9900, 0, 8'h99, 8'h01, 8'h00, 8'h00);
    add("pop99",      0, 0, 16'h0000, 1, 8'h00, 8'h00, 8'h00, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clock);
      reset = v.rst; selector = v.sel; source = v.src; pop = v.pop;
      exp_q.push_back(v);
      @(posedge clock);
      #1;
      e = exp_q.pop_front();
      chk_all(e.name, e.e0, e.e1, e.e2, e.e3);
    end

    // Hand-written corner: sustained push+pop at one entry keeps occupancy steady.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      reset = 1'b0; selector = 2'd1; source = 16'(8'hC0 + i); pop = (i != 0);
      @(posedge clock);
      #1;
      chk_all("stream", 8'(8'hC0 + i), 8'h01, 8'h00, 8'h00);
    end
    @(negedge clock);
    selector = 2'd0; pop = 1'b1;
    @(posedge clock);
    #1;
    chk_all("stream_end", 8'h00, 8'h00, 8'h00, 8'h00);

    // Random phase with a queue model as scoreboard.
    model_q.delete();
    m_ovf = 1'b0; m_udf = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic       pop_ok, push_req, push_ok;
      logic [7:0] w;
      @(negedge clock);
      selector = 2'($urandom_range(0, 3));
      source   = 16'($urandom);
      pop      = 1'($urandom_range(0, 1));
      push_req = (selector == 2'd1) || (selector == 2'd2);
      w        = (selector == 2'd2) ? source[15:8] : source[7:0];
      pop_ok   = pop && (model_q.size() != 0);
      push_ok  = push_req && ((model_q.size() != DEPTH) || pop_ok);
      if (pop && model_q.size() == 0) m_udf = 1'b1;
      if (push_req && !push_ok)       m_ovf = 1'b1;
      if (pop_ok)  void'(model_q.pop_front());
      if (push_ok) model_q.push_back(w);
      @(posedge clock);
      #1;
      chk_all("rand",
              (model_q.size() != 0) ? model_q[0] : 8'h00,
              8'(model_q.size()),
              (model_q.size() == DEPTH) ? 8'hFF : 8'h00,
              {6'b0, m_udf, m_ovf});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
